vec_mem_stage: RTL

- Parametrised vector execute + data-memory stage: lane-wise execute (pass/mask/broadcast/rotate) in parallel with a lane-masked access to an internal word-wide data memory.
- Adds valid/ready flow control, a 2-stage pipeline, async active-low reset, per-lane write enables and address-range checking.
- Sits between the vector register-read stage and writeback.

---
 rtl/vec_mem_stage_if.sv | 40 ++++
 rtl/vec_mem_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : vec_mem_stage_if
// Description : Request/response bundle between register-read, the vector
//               execute/memory stage and writeback.
// Revision    : 1.0 - initial release
// ============================================================================
interface vec_mem_stage_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 15
);
    localparam int W = LANES * LANE_W;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op;
    logic [LANES-1:0]  lane_mask;
    logic [W-1:0]      veca;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] dir;
    logic [W-1:0]      data_in;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      vec_out;
    logic [W-1:0]      data_out;
    logic              addr_err;

    modport master (
        output in_valid, op, lane_mask, veca, mem_en, mem_we, dir, data_in, out_ready,
        input  in_ready, out_valid, vec_out, data_out, addr_err
    );

    modport slave (
        input  in_valid, op, lane_mask, veca, mem_en, mem_we, dir, data_in, out_ready,
        output in_ready, out_valid, vec_out, data_out, addr_err
    );
endinterface
`default_nettype wire

// File: rtl/vec_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : vec_mem_stage
// Description : Two-stage vector execute (pass/mask/bcast/rotate) with a
//               lane-masked access to an internal word-wide data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_mem_stage #(
    parameter int LANES  = 4,
    parameter int LANE_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 15
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    vec_mem_stage_if.slave  bus
);
    localparam int W     = LANES * LANE_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

    // S1: captured request
    logic              s1_valid_q,  s1_valid_d;
    logic [1:0]        s1_op_q,     s1_op_d;
    logic [LANES-1:0]  s1_mask_q,   s1_mask_d;
    logic [W-1:0]      s1_veca_q,   s1_veca_d;
    logic              s1_en_q,     s1_en_d;
    logic              s1_we_q,     s1_we_d;
    logic [ADDR_W-1:0] s1_dir_q,    s1_dir_d;
    logic [W-1:0]      s1_data_q,   s1_data_d;

    // S2: result presented downstream
    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      vec_out_q,   vec_out_d;
    logic [W-1:0]      data_out_q,  data_out_d;
    logic              addr_err_q,  addr_err_d;

    logic [W-1:0]      mem_q [DEPTH];

    logic              w_adv;
    logic [W-1:0]      w_exec;
    logic [LANE_W-1:0] w_bcast_lane;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic [W-1:0]      w_old;
    logic [W-1:0]      w_merged;
    logic [W-1:0]      w_data_res;
    logic              w_mem_wr;

    assign w_adv       = ~(out_valid_q & ~bus.out_ready);
    assign bus.in_ready = w_adv;

    assign bus.out_valid = out_valid_q;
    assign bus.vec_out   = vec_out_q;
    assign bus.data_out  = data_out_q;
    assign bus.addr_err  = addr_err_q;

    // Lowest set mask bit wins the broadcast; scanning downward leaves it last.
    always_comb begin
        w_bcast_lane = '0;
        w_exec       = s1_veca_q;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (s1_mask_q[i]) begin
                w_bcast_lane = s1_veca_q[i*LANE_W +: LANE_W];
            end
        end
        case (s1_op_q)
            2'b00: w_exec = s1_veca_q;
            2'b01: begin
                for (int i = 0; i < LANES; i++) begin
                    w_exec[i*LANE_W +: LANE_W] = s1_mask_q[i] ? s1_veca_q[i*LANE_W +: LANE_W]
                                                              : '0;
                end
            end
            2'b10: begin
                for (int i = 0; i < LANES; i++) begin
                    w_exec[i*LANE_W +: LANE_W] = w_bcast_lane;
                end
            end
            default: begin
                for (int i = 0; i < LANES; i++) begin
                    w_exec[i*LANE_W +: LANE_W] =
                        s1_veca_q[((i + LANES - 1) % LANES)*LANE_W +: LANE_W];
                end
            end
        endcase
    end

    assign w_in_range = ({1'b0, s1_dir_q} < c_DEPTH);
    assign w_idx      = s1_dir_q[IDX_W-1:0];
    assign w_old      = mem_q[w_idx];

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < LANES; i++) begin
            if (s1_mask_q[i]) begin
                w_merged[i*LANE_W +: LANE_W] = s1_data_q[i*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        w_data_res = '0;
        if (s1_en_q && w_in_range) begin
            w_data_res = s1_we_q ? w_merged : w_old;
        end
    end

    // The memory is touched only on the edge that moves S1 into S2.
    assign w_mem_wr = w_adv & s1_valid_q & s1_en_q & s1_we_q & w_in_range;

    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            mem_q[w_idx] <= w_merged;
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_mask_d   = s1_mask_q;
        s1_veca_d   = s1_veca_q;
        s1_en_d     = s1_en_q;
        s1_we_d     = s1_we_q;
        s1_dir_d    = s1_dir_q;
        s1_data_d   = s1_data_q;
        out_valid_d = out_valid_q;
        vec_out_d   = vec_out_q;
        data_out_d  = data_out_q;
        addr_err_d  = addr_err_q;
        if (w_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_op_d   = bus.op;
                s1_mask_d = bus.lane_mask;
                s1_veca_d = bus.veca;
                s1_en_d   = bus.mem_en;
                s1_we_d   = bus.mem_we;
                s1_dir_d  = bus.dir;
                s1_data_d = bus.data_in;
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                vec_out_d  = w_exec;
                data_out_d = w_data_res;
                addr_err_d = s1_en_q & ~w_in_range;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_mask_q   <= '0;
            s1_veca_q   <= '0;
            s1_en_q     <= 1'b0;
            s1_we_q     <= 1'b0;
            s1_dir_q    <= '0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            vec_out_q   <= '0;
            data_out_q  <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_mask_q   <= s1_mask_d;
            s1_veca_q   <= s1_veca_d;
            s1_en_q     <= s1_en_d;
            s1_we_q     <= s1_we_d;
            s1_dir_q    <= s1_dir_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            vec_out_q   <= vec_out_d;
            data_out_q  <= data_out_d;
            addr_err_q  <= addr_err_d;
        end
    end
endmodule
`default_nettype wire
